// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and the default operand width.
package multiplier_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_ripple.sv
// WIDTH-bit ripple-carry adder chained from full_adder cells.
// Combinational, no flow control.
module adder_ripple #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, purely combinational.
// No latency, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiplier_sequential.sv
// Sequential shift-add multiplier, signed or unsigned; out_valid WIDTH+1 cycles after accept.
// Product held in DONE until out_ready; in_ready low while BUSY or DONE.
module multiplier_sequential
  import multiplier_pkg::*;
#(
  parameter int  WIDTH         = DEFAULT_WIDTH,
  localparam int PRODUCT_WIDTH = WIDTH + WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_signed,
  input  logic [WIDTH-1:0]         alpha,
  input  logic [WIDTH-1:0]         beta,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PRODUCT_WIDTH-1:0] product
);

  localparam int ACC_W = PRODUCT_WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d, acc_next;
  logic [WIDTH-1:0]         mcand_q, mcand_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sign_q, sign_d;
  logic [PRODUCT_WIDTH-1:0] product_q, product_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic [WIDTH-1:0]         alpha_mag, beta_mag;
  logic [WIDTH:0]           add_b, add_sum;
  logic                     add_cout;
  logic [PRODUCT_WIDTH-1:0] mag_final;

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), exact as unsigned.
  assign alpha_mag = (in_signed && alpha[WIDTH-1]) ? -alpha : alpha;
  assign beta_mag  = (in_signed && beta[WIDTH-1])  ? -beta  : beta;

  // Multiplier lives in the low half of the accumulator; its LSB gates each add.
  assign add_b = acc_q[0] ? {1'b0, mcand_q} : '0;

  adder_ripple #(
    .WIDTH (WIDTH + 1)
  ) u_add (
    .a    (acc_q[ACC_W-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign acc_next  = {add_cout, add_sum, acc_q[WIDTH-1:1]};
  assign mag_final = acc_next[PRODUCT_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d    = alpha_mag;
          acc_d      = {{(WIDTH + 1){1'b0}}, beta_mag};
          cnt_d      = '0;
          sign_d     = in_signed & (alpha[WIDTH-1] ^ beta[WIDTH-1]);
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          product_d   = sign_q ? -mag_final : mag_final;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_multiplier_sequential.sv
// Bench for multiplier_sequential at WIDTH=4 and WIDTH=16: directed vectors,
// exhaustive 4-bit sweep, throughput, back-pressure and mid-operation reset.
module tb_multiplier_sequential;

  typedef struct {
    logic        sel16;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    int          c0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel16;
  logic        in_valid_c, in_signed_c, out_ready_c;
  logic [31:0] a_c, b_c;

  logic        in_valid4, in_ready4, out_valid4;
  logic [7:0]  product4;
  logic        in_valid16, in_ready16, out_valid16;
  logic [31:0] product16;

  logic        mon_ov;
  logic [63:0] mon_prod;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int rise_cyc   = 0;
  int ov_rises   = 0;
  logic ov_prev  = 1'b0;
  exp_t scb[$];

  assign in_valid4  = in_valid_c & ~sel16;
  assign in_valid16 = in_valid_c & sel16;
  assign mon_ov     = sel16 ? out_valid16 : out_valid4;
  assign mon_prod   = sel16 ? {32'b0, product16} : {56'b0, product4};

  multiplier_sequential #(.WIDTH(4)) dut4 (
    .clock     (clk),
    .reset     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_signed (in_signed_c),
    .alpha     (a_c[3:0]),
    .beta      (b_c[3:0]),
    .out_valid (out_valid4),
    .out_ready (out_ready_c),
    .product   (product4)
  );

  multiplier_sequential #(.WIDTH(16)) dut16 (
    .clock     (clk),
    .reset     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_signed (in_signed_c),
    .alpha     (a_c[15:0]),
    .beta      (b_c[15:0]),
    .out_valid (out_valid16),
    .out_ready (out_ready_c),
    .product   (product16)
  );

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, p;
    logic [63:0] mask;
    sa  = longint'(a) & ((longint'(1) << w) - 1);
    sbv = longint'(b) & ((longint'(1) << w) - 1);
    if (s && a[w-1]) sa  = sa  - (longint'(1) << w);
    if (s && b[w-1]) sbv = sbv - (longint'(1) << w);
    p    = sa * sbv;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Scoreboard: pop on every output handshake, latency measured from the rise of out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (mon_ov && !ov_prev) begin
      rise_cyc = cyc;
      ov_rises++;
    end
    ov_prev = mon_ov;
    if (mon_ov && out_ready_c) begin
      if (scb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out: got product %0h, expected no output", mon_prod);
      end else begin
        e = scb.pop_front();
        chk("product", mon_prod, e.prod);
        chk("latency", 64'(rise_cyc - e.c0), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic sel, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] e, input bit push);
    int k;
    sel16       = sel;
    in_signed_c = s;
    a_c         = a;
    b_c         = b;
    in_valid_c  = 1'b1;
    k = 0;
    while (!(sel ? in_ready16 : in_ready4) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept", 64'(sel ? in_ready16 : in_ready4), 64'd1);
    if (push) scb.push_back('{prod: e, c0: cyc, lat: (sel ? 17 : 5)});
    @(negedge clk);
    in_valid_c  = 1'b0;
    a_c         = $urandom;
    b_c         = $urandom;
    in_signed_c = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && scb.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(scb.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   hs[3];
    int   n;
    int   rises0;
    logic [31:0] ta, tb;
    logic        ts;

    vecs[0] = '{1'b0, 1'b0, 32'd15,     32'd15,     64'hE1};
    vecs[1] = '{1'b0, 1'b1, 32'h8,      32'h8,      64'h40};
    vecs[2] = '{1'b0, 1'b1, 32'h8,      32'h7,      64'hC8};
    vecs[3] = '{1'b0, 1'b1, 32'h7,      32'hF,      64'hF9};
    vecs[4] = '{1'b0, 1'b0, 32'h0,      32'hF,      64'h00};
    vecs[5] = '{1'b1, 1'b0, 32'h0,      32'hFFFF,   64'h0};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF,   32'hFFFF,   64'hFFFE0001};
    vecs[7] = '{1'b1, 1'b1, 32'h8000,   32'h8000,   64'h40000000};
    vecs[8] = '{1'b1, 1'b1, 32'hFFFF,   32'h1,      64'hFFFFFFFF};

    rst_n       = 1'b0;
    sel16       = 1'b0;
    in_valid_c  = 1'b0;
    in_signed_c = 1'b0;
    out_ready_c = 1'b1;
    a_c         = '0;
    b_c         = '0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready4",   64'(in_ready4),   64'd1);
    chk("rst_out_valid4",  64'(out_valid4),  64'd0);
    chk("rst_product4",    64'(product4),    64'd0);
    chk("rst_in_ready16",  64'(in_ready16),  64'd1);
    chk("rst_out_valid16", 64'(out_valid16), 64'd0);
    chk("rst_product16",   64'(product16),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].sel16, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_drain();
    end

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          ta = 32'(a);
          tb = 32'(b);
          ts = 1'(s);
          issue(1'b0, ts, ta, tb, ref_mul(4, ts, ta, tb), 1'b1);
          wait_drain();
        end

    // Back-to-back: in_valid held high, accepts spaced WIDTH+2 cycles apart.
    sel16 = 1'b0;
    n = 0;
    in_valid_c = 1'b1;
    for (int k = 0; k < 60 && n < 3; k++) begin
      ta = 32'((n * 5 + 3) % 16);
      tb = 32'((n * 7 + 9) % 16);
      ts = 1'(n % 2);
      a_c = ta;
      b_c = tb;
      in_signed_c = ts;
      if (in_ready4) begin
        scb.push_back('{prod: ref_mul(4, ts, ta, tb), c0: cyc, lat: 5});
        hs[n] = cyc;
        n++;
      end
      @(negedge clk);
    end
    in_valid_c = 1'b0;
    chk("b2b_accepts", 64'(n), 64'd3);
    chk("b2b_gap0", 64'(hs[1] - hs[0]), 64'd6);
    chk("b2b_gap1", 64'(hs[2] - hs[1]), 64'd6);
    wait_drain();

    // Back-pressure: product held, new requests ignored while DONE.
    out_ready_c = 1'b0;
    issue(1'b0, 1'b0, 32'd9, 32'd13, 64'h75, 1'b1);
    for (int k = 0; k < 40 && !out_valid4; k++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid_c = 1'b1;
      a_c = 32'(i);
      b_c = ~32'(i);
      chk("bp_out_valid", 64'(out_valid4), 64'd1);
      chk("bp_product",   64'(product4),   64'h75);
      chk("bp_in_ready",  64'(in_ready4),  64'd0);
      @(negedge clk);
    end
    rises0 = ov_rises;
    @(posedge clk);
    #2;
    in_valid_c  = 1'b0;
    out_ready_c = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid4), 64'd0);
    chk("bp_release_ready", 64'(in_ready4),  64'd1);
    chk("bp_queue_empty",   64'(scb.size()), 64'd0);
    repeat (8) @(negedge clk);
    chk("bp_no_capture", 64'(ov_rises - rises0), 64'd0);

    // Reset at BUSY step 2 aborts without output.
    issue(1'b0, 1'b1, 32'd5, 32'd11, 64'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready",  64'(in_ready4),  64'd1);
    chk("midrst_out_valid", 64'(out_valid4), 64'd0);
    chk("midrst_product",   64'(product4),   64'd0);
    rst_n  = 1'b1;
    rises0 = ov_rises;
    repeat (12) @(negedge clk);
    chk("midrst_no_output", 64'(ov_rises - rises0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
